led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for the board LED bank: a prescaler divides the system clock into a step tick, and a pattern engine advances one of four selectable patterns across `LED_NUM` LEDs on each tick. It generalises the single fixed-rate all-LED toggle to configurable width, rate, output polarity, run-time mode selection and pause.

## Interface
- `LED_NUM`, 4: number of LEDs, ≥1.
- `CNT_W`, 25: prescaler counter width.
- `CNT_MAX`, 25'd24_999_999: terminal count. Step period is `CNT_MAX+1` enabled cycles. Must fit in `CNT_W`. 0 means a step on every enabled cycle.
- `ACTIVE_LOW`, 1: 1 means `led` is driven inverted (0 = lit).

- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: 1 runs; 0 freezes the prescaler and pattern.
- `mode` input 2: requested pattern. 0 BLINK, 1 RUN, 2 PINGPONG, 3 FILL.
- `mode_wr` input 1: single-cycle strobe that loads `mode`.
- `led` output LED_NUM: LED drive, `ACTIVE_LOW ? ~pat : pat`.
- `tick` output 1: step strobe.
- `cur_mode` output 2: active mode.

## Operation
- Reset values: `cnt`=0, `pat`=0, `dir`=up, `cur_mode`=BLINK, `tick`=0. `led` resets to all ones if `ACTIVE_LOW`, otherwise all zeros.
- Prescaler: when `en`=1, `cnt` increments. At `cnt==CNT_MAX` it wraps to 0. When `en`=0, `cnt` holds.
- `tick` = (`cnt==CNT_MAX`) && `en`. It is a decode of the registered `cnt`, so it is high for exactly one cycle per period.
- On a clock edge with `tick`=1 and `mode_wr`=0, `pat` steps as follows:
  - BLINK: `pat <= ~pat`. Sequence all-off, all-on, …
  - RUN: rotate left by 1. Sequence 0001, 0010, 0100, 1000, 0001.
  - PINGPONG: one-hot bounce. 0001→0010→0100→1000→0100→0010→0001. `dir` flips on the step that lands on bit `LED_NUM-1` or bit 0, with no end repeat. Period is 2·(LED_NUM−1).
  - FILL: `pat <= {pat[LED_NUM-2:0],1'b1}` until all ones, then the next step gives all zeros. Sequence 0000, 0001, 0011, 0111, 1111, 0000. Period is LED_NUM+1.
- Mode load: on an edge with `mode_wr`=1, the block loads `cur_mode<=mode`, clears `cnt` to 0, sets `dir`=up, and loads `pat` with the initial pattern for the mode. Initial patterns: BLINK 0, RUN 1, PINGPONG 1, FILL 0. A rewrite of the same mode also restarts it.
- `mode_wr` is honoured regardless of `en`.
- Simultaneous `mode_wr` and `tick`: the mode load wins and the step is discarded. `tick` is still seen high for that cycle.
- `LED_NUM`=1: RUN and PINGPONG hold at 1. FILL alternates 1/0.
- `pat` is always a legal pattern for `cur_mode`. There are no illegal states.

## Timing
- A `pat` update is visible on `led` the cycle after `tick`, which is the same cycle `cnt` reads 0. There is no further output pipeline.
- After `mode_wr` at edge k: the initial pattern appears on `led` after edge k. The first `tick` occurs `CNT_MAX` enabled cycles later, and the first step shows after edge k+CNT_MAX+1 (all cycles enabled).
- `en` deassert: the freeze takes effect at the same edge, with no partial count. Reasserting `en` resumes from the held `cnt`.
- Asynchronous `rst` mid-period or mid-pattern: outputs go to reset values immediately, without waiting for a clock edge. Release is synchronised by the integrator.

## Structure
- Package `led_pkg`:
  - `led_mode_t` enum: BLINK=0, RUN=1, PINGPONG=2, FILL=3.
  - `DIR_UP`/`DIR_DN` constants.
- Sub-module `led_prescaler`: parameters `CNT_W` and `CNT_MAX`. Ports `clk`, `rst`, `en`, `clr`, `cnt`, `tick`. It is reusable by other timed blocks.
- The top level holds `cur_mode`, `pat`, `dir`, and the next-pattern case statement.

## Test plan
Bench settings: `CNT_MAX`=9, `LED_NUM`=4, `ACTIVE_LOW`=1.

1. Reset, then `en`=1 with no `mode_wr`: `led`=1111 during reset. `tick` pulses every 10 cycles. `led` alternates 0000 and 1111 each period.
2. `mode_wr` with `mode`=RUN: `led` is 1110 immediately after. It then steps 1101, 1011, 0111, 1110 at 10-cycle spacing.
3. PINGPONG and FILL over 2 full periods each: `pat` follows 1,2,4,8,4,2,1,… and 0,1,3,7,F,0,…. `cur_mode` matches the requested mode.
4. `en`=0 for 25 cycles mid-period at `cnt`=4: `led`, `cnt` and `tick` are frozen. On re-enable the next `tick` arrives 5 cycles later.
5. `mode_wr` asserted in the `tick` cycle: the step is dropped. The new mode's initial pattern appears and `cnt`=0.
6. `rst` pulse mid-pattern, between clock edges: `led`=1111 and `cur_mode`=BLINK asynchronously. The BLINK sequence restarts after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: pattern modes and
// bounce direction encodings.
package led_pkg;

  typedef enum logic [1:0] {
    BLINK    = 2'd0,
    RUN      = 2'd1,
    PINGPONG = 2'd2,
    FILL     = 2'd3
  } led_mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler with synchronous clear; tick is a decode of the
// registered count, so it lasts exactly one enabled cycle per period.
module led_prescaler #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = en && (cnt == CNT_MAX);

  // Clear beats enable so a mode load restarts the period even while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: the prescaler tick advances one of four patterns
// across LED_NUM LEDs; mode_wr reloads the mode and restarts its period.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int               LED_NUM    = 4,
  parameter int               CNT_W      = 25,
  parameter logic [CNT_W-1:0] CNT_MAX    = 25'd24_999_999,
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               mode_wr,
  output logic [LED_NUM-1:0] led,
  output logic               tick,
  output logic [1:0]         cur_mode
);

  led_mode_t          mode_q, mode_nxt;
  logic [LED_NUM-1:0] pat, pat_nxt;
  logic               dir, dir_nxt;
  logic [CNT_W-1:0]   cnt;

  led_prescaler #(
    .CNT_W  (CNT_W),
    .CNT_MAX(CNT_MAX)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (mode_wr),
    .cnt (cnt),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= BLINK;
      pat    <= '0;
      dir    <= DIR_UP;
    end else begin
      mode_q <= mode_nxt;
      pat    <= pat_nxt;
      dir    <= dir_nxt;
    end
  end

  // A mode load takes priority over a coincident tick, discarding that step.
  always_comb begin
    mode_nxt = mode_q;
    pat_nxt  = pat;
    dir_nxt  = dir;
    if (mode_wr) begin
      mode_nxt = led_mode_t'(mode);
      dir_nxt  = DIR_UP;
      case (led_mode_t'(mode))
        RUN, PINGPONG: pat_nxt = LED_NUM'(1);
        default:       pat_nxt = '0;
      endcase
    end else if (tick) begin
      case (mode_q)
        BLINK: pat_nxt = ~pat;
        RUN:   pat_nxt = (pat << 1) | (pat >> (LED_NUM - 1));
        PINGPONG: begin
          // Direction flips on the step that lands on an end bit.
          if (LED_NUM == 1) begin
            pat_nxt = pat;
          end else if (dir == DIR_UP) begin
            pat_nxt = pat << 1;
            if (pat_nxt[LED_NUM-1]) dir_nxt = DIR_DN;
          end else begin
            pat_nxt = pat >> 1;
            if (pat_nxt[0]) dir_nxt = DIR_UP;
          end
        end
        FILL:    pat_nxt = (&pat) ? '0 : ((pat << 1) | LED_NUM'(1));
        default: pat_nxt = pat;
      endcase
    end
  end

  assign led      = ACTIVE_LOW ? ~pat : pat;
  assign cur_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen with a 10-cycle step
// period, four LEDs and active-low drive.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       mode_wr;
  logic [3:0] led;
  logic       tick;
  logic [1:0] cur_mode;

  int checks;
  int errors;

  logic [3:0] ppSeq [12];
  logic [3:0] fillSeq [10];
  logic [3:0] runSeq [4];
  logic [3:0] frozenLed;

  led_pattern_gen #(
    .LED_NUM   (4),
    .CNT_W     (25),
    .CNT_MAX   (25'd9),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .mode_wr (mode_wr),
    .led     (led),
    .tick    (tick),
    .cur_mode(cur_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enIn, input logic [1:0] modeIn, input logic wrIn);
    en      = enIn;
    mode    = modeIn;
    mode_wr = wrIn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPat(input string tag, input logic [3:0] expPat);
    logic [3:0] expLed;
    expLed = ~expPat;
    checkOutput(tag, led, expLed);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ppSeq   = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
    fillSeq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h0};
    runSeq  = '{4'hD, 4'hB, 4'h7, 4'hE};

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0);
    cycles(2);
    checkOutput("reset_led", led, 32'hF);
    checkOutput("reset_tick", tick, 32'h0);
    checkOutput("reset_mode", cur_mode, 32'h0);
    checkOutput("reset_cnt", dut.cnt, 32'h0);

    // BLINK after reset
    rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 1'b0);
    cycles(8);
    checkOutput("blink_cnt8", dut.cnt, 32'd8);
    checkOutput("blink_notick", tick, 32'h0);
    cycles(1);
    checkOutput("blink_tick", tick, 32'h1);
    checkOutput("blink_led_pre", led, 32'hF);
    cycles(1);
    checkOutput("blink_tick_off", tick, 32'h0);
    checkOutput("blink_on", led, 32'h0);
    checkOutput("blink_cnt0", dut.cnt, 32'h0);
    cycles(9);
    checkOutput("blink_tick2", tick, 32'h1);
    cycles(1);
    checkOutput("blink_off", led, 32'hF);

    // RUN
    applyStimulus(1'b1, 2'd1, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("run_init", led, 32'hE);
    checkOutput("run_mode", cur_mode, 32'd1);
    checkOutput("run_cnt", dut.cnt, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycles(10);
      checkOutput("run_step", led, 32'(runSeq[i]));
    end

    // PINGPONG over two bounce periods
    applyStimulus(1'b1, 2'd2, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkPat("pp_init", 4'h1);
    checkOutput("pp_mode", cur_mode, 32'd2);
    for (int i = 0; i < 12; i++) begin
      cycles(10);
      checkPat("pp_step", ppSeq[i]);
    end

    // FILL over two periods
    applyStimulus(1'b1, 2'd3, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 2'd3, 1'b0);
    checkPat("fill_init", 4'h0);
    checkOutput("fill_mode", cur_mode, 32'd3);
    for (int i = 0; i < 10; i++) begin
      cycles(10);
      checkPat("fill_step", fillSeq[i]);
    end

    // Freeze at cnt=4 for 25 cycles
    cycles(4);
    checkOutput("freeze_cnt_pre", dut.cnt, 32'd4);
    frozenLed = led;
    applyStimulus(1'b0, 2'd3, 1'b0);
    cycles(25);
    checkOutput("freeze_cnt", dut.cnt, 32'd4);
    checkOutput("freeze_tick", tick, 32'h0);
    checkOutput("freeze_led", led, 32'(frozenLed));
    checkOutput("freeze_mode", cur_mode, 32'd3);
    applyStimulus(1'b1, 2'd3, 1'b0);
    cycles(4);
    checkOutput("resume_notick", tick, 32'h0);
    checkOutput("resume_cnt8", dut.cnt, 32'd8);
    cycles(1);
    checkOutput("resume_tick", tick, 32'h1);

    // Mode load in the tick cycle drops the FILL step (which would give 0001)
    applyStimulus(1'b1, 2'd0, 1'b1);
    #1;
    checkOutput("collide_tick", tick, 32'h1);
    cycles(1);
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkOutput("collide_led", led, 32'hF);
    checkOutput("collide_mode", cur_mode, 32'd0);
    checkOutput("collide_cnt", dut.cnt, 32'h0);
    cycles(10);
    checkOutput("collide_blink", led, 32'h0);

    // Asynchronous reset mid-pattern
    applyStimulus(1'b1, 2'd1, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    cycles(10);
    checkOutput("prerst_led", led, 32'hD);
    checkOutput("prerst_mode", cur_mode, 32'd1);
    cycles(3);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_led", led, 32'hF);
    checkOutput("arst_mode", cur_mode, 32'd0);
    checkOutput("arst_cnt", dut.cnt, 32'h0);
    #2;
    rst = 1'b0;
    cycles(9);
    checkOutput("rst_blink_tick", tick, 32'h1);
    checkOutput("rst_blink_pre", led, 32'hF);
    cycles(1);
    checkOutput("rst_blink_on", led, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
